hazard_unit_v2: RTL and testbench
=================================

HAZARD_UNIT_V2 -- requirements
Module: hazard_unit_v2

Interface
REQ-001 SHALL have parameters: XLEN, default 32, datapath/PC width; LOAD_LAT, default 1, load-use bubble count (1..3); FLUSH_DEPTH, default 1, fetch-side flush cycles per redirect (1..3); CNT_W, default 16, width of the performance counters.
REQ-002 SHALL use one clock; reset is synchronous and active-high (ports clk, rst).
REQ-003 clk  input  1  clock; rst  input  1  synchronous active-high reset.
REQ-004 branch  input  2  EX control-flow type: 00 none, 01 conditional, 10 JALR, 11 JAL.
REQ-005 func3  input  3  EX branch condition code; alu_zero  input  1  ALU zero flag.
REQ-006 pc_imm  input  XLEN  PC+imm target; alu_out  input  XLEN  JALR target.
REQ-007 ex_mem_read  input  1  EX instruction is a load; ex_rd  input  5  EX destination register.
REQ-008 id_rs1, id_rs2  input  5 each  ID source registers; id_use_rs1, id_use_rs2  input  1 each  source actually read.
REQ-009 ex_rs1, ex_rs2  input  5 each  EX source registers for forwarding.
REQ-010 mem_rd  input  5, mem_reg_write  input  1  MEM writeback; wb_rd  input  5, wb_reg_write  input  1  WB writeback.
REQ-011 stall_if, stall_id  output  1 each  hold PC / IF-ID register; flush_id, flush_ex  output  1 each  bubble IF-ID / ID-EX.
REQ-012 redirect_valid  output  1, redirect_pc  output  XLEN  PC override.
REQ-013 fwd_a, fwd_b  output  2 each  EX operand select: 00 regfile, 01 WB, 10 MEM.
REQ-014 stall_cnt, flush_cnt  output  CNT_W each  performance counters.

Function
REQ-015 Branch taken (combinational): func3 000/101/111 -> alu_zero; 001/100/110 -> ~alu_zero; 010/011 -> 0.
REQ-016 redirect_valid SHALL be 1 when branch=01 and taken, or when branch=1x; redirect_pc = pc_imm for 01/11, {alu_out[XLEN-1:1],1'b0} for 10, otherwise 0; combinational, same cycle.
REQ-017 Load-use hazard (combinational) = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)); register x0 SHALL never raise a hazard.
REQ-018 FSM states: IDLE, LD_WAIT, FLUSH; a registered down-counter cnt (2 bits) tracks remaining cycles.
REQ-019 IDLE, redirect: flush_id=flush_ex=1 that cycle; if FLUSH_DEPTH>1 go to FLUSH with cnt=FLUSH_DEPTH-1, else stay IDLE.
REQ-020 IDLE, load-use hazard and no redirect: stall_if=stall_id=flush_ex=1 that cycle; if LOAD_LAT>1 go to LD_WAIT with cnt=LOAD_LAT-1.
REQ-021 LD_WAIT: stall_if=stall_id=flush_ex=1 unconditionally; decrement cnt; return to IDLE when cnt reaches 1 at the clock edge; total stall = exactly LOAD_LAT cycles.
REQ-022 FLUSH: flush_id=1, stall outputs 0; decrement cnt; return to IDLE when cnt reaches 1 at the clock edge.
REQ-023 Redirect has priority over a load stall in every state: stall outputs forced 0 that cycle, flush_id=flush_ex=1, FSM to FLUSH (cnt=FLUSH_DEPTH-1) or IDLE if FLUSH_DEPTH=1.
REQ-024 Redirect while in FLUSH SHALL reload cnt=FLUSH_DEPTH-1.
REQ-025 fwd_a = 10 if mem_reg_write & mem_rd!=0 & mem_rd==ex_rs1, else 01 if wb_reg_write & wb_rd!=0 & wb_rd==ex_rs1, else 00; MEM has priority; fwd_b identical using ex_rs2; combinational.
REQ-026 stall_cnt increments by 1 each cycle stall_id=1; flush_cnt increments by 1 each cycle redirect_valid=1; both saturate at all-ones, no wrap.

Reset
REQ-027 rst=1 at a clock edge SHALL force state IDLE, cnt=0, stall_cnt=flush_cnt=0, including mid LD_WAIT/FLUSH.
REQ-028 While rst=1, stall_if, stall_id, flush_id and flush_ex SHALL be 0; redirect and forwarding outputs remain combinational.

Verification
REQ-029 LOAD_LAT=2: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for one cycle -> stall_id=1 for exactly 2 cycles, stall_cnt=2.
REQ-030 ex_mem_read=1, ex_rd=0, id_rs1=0 -> no stall; id_use_rs2=0 with id_rs2==ex_rd -> no stall.
REQ-031 branch=01, func3=001, alu_zero=0, pc_imm=0x100 -> redirect_valid=1, redirect_pc=0x100, flush_id=flush_ex=1; alu_zero=1 -> redirect_valid=0, redirect_pc=0.
REQ-032 branch=10, alu_out=0x203 -> redirect_pc=0x202; simultaneous load hazard -> stall_id=0, flush_cnt+1.
REQ-033 mem_rd=wb_rd=ex_rs1=7, both writes=1 -> fwd_a=10; mem_reg_write=0 -> fwd_a=01.
REQ-034 FLUSH_DEPTH=3, redirect then rst asserted in 2nd cycle -> next cycle flush_id=0, state IDLE; counter saturation checked with CNT_W=4: 20 stall cycles -> stall_cnt=15.

Source files
------------

// File: rtl/hazard_unit_v2.sv
// Pipeline hazard control: branch redirect, load-use stall, EX operand forwarding,
// plus saturating stall/flush performance counters. State is visible on dbg_state.
module hazard_unit_v2 #(
  parameter int XLEN        = 32,
  parameter int LOAD_LAT    = 1,
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       branch,
  input  logic [2:0]       func3,
  input  logic             alu_zero,
  input  logic [XLEN-1:0]  pc_imm,
  input  logic [XLEN-1:0]  alu_out,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  output logic             stall_if,
  output logic             stall_id,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, LD_WAIT = 2'd1, FLUSH = 2'd2} state_t;

  localparam logic [1:0] LD_INIT = 2'(LOAD_LAT - 1);
  localparam logic [1:0] FL_INIT = 2'(FLUSH_DEPTH - 1);

  state_t           r_state;
  logic [1:0]       r_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_taken;
  logic             w_load_use;
  logic             w_unused_lsb;

  assign w_unused_lsb = alu_out[0];

  always_comb begin
    w_taken = 1'b0;
    case (func3)
      3'b000, 3'b101, 3'b111: w_taken = alu_zero;
      3'b001, 3'b100, 3'b110: w_taken = ~alu_zero;
      default:                w_taken = 1'b0;
    endcase
  end

  // The target is only driven when a redirect actually happens; otherwise it reads 0.
  always_comb begin
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (branch)
      2'b01: if (w_taken) begin
        redirect_valid = 1'b1;
        redirect_pc    = pc_imm;
      end
      2'b10: begin
        redirect_valid = 1'b1;
        redirect_pc    = {alu_out[XLEN-1:1], 1'b0};
      end
      2'b11: begin
        redirect_valid = 1'b1;
        redirect_pc    = pc_imm;
      end
      default: ;
    endcase
  end

  assign w_load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  // A redirect squashes everything younger, so it overrides any pending stall.
  always_comb begin
    stall_if = 1'b0;
    stall_id = 1'b0;
    flush_id = 1'b0;
    flush_ex = 1'b0;
    if (!rst) begin
      if (redirect_valid) begin
        flush_id = 1'b1;
        flush_ex = 1'b1;
      end else begin
        case (r_state)
          IDLE: if (w_load_use) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
          end
          LD_WAIT: begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
          end
          FLUSH:   flush_id = 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
    end else if (redirect_valid) begin
      if (FLUSH_DEPTH > 1) begin
        r_state <= FLUSH;
        r_cnt   <= FL_INIT;
      end else begin
        r_state <= IDLE;
        r_cnt   <= 2'd0;
      end
    end else begin
      case (r_state)
        IDLE: if (w_load_use && (LOAD_LAT > 1)) begin
          r_state <= LD_WAIT;
          r_cnt   <= LD_INIT;
        end
        LD_WAIT, FLUSH: begin
          if (r_cnt <= 2'd1) begin
            r_state <= IDLE;
            r_cnt   <= 2'd0;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stall_id && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (redirect_valid && (r_flush_cnt != {CNT_W{1'b1}}))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  // MEM holds the younger result, so it wins over WB; x0 is never forwarded.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rs1))    fwd_a = 2'b10;
    else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rs1))  fwd_a = 2'b01;
    if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rs2))    fwd_b = 2'b10;
    else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rs2))  fwd_b = 2'b01;
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_hazard_unit_v2.sv
// Directed bench for hazard_unit_v2: combinational vector table on a single-cycle
// configuration, plus multi-cycle sequences on a LOAD_LAT=2 / FLUSH_DEPTH=3 instance.
module tb_hazard_unit_v2;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  branch;
  logic [2:0]  func3;
  logic        alu_zero;
  logic [31:0] pc_imm, alu_out;
  logic        ex_mem_read;
  logic [4:0]  ex_rd, id_rs1, id_rs2, ex_rs1, ex_rs2, mem_rd, wb_rd;
  logic        id_use_rs1, id_use_rs2, mem_reg_write, wb_reg_write;

  logic        a_stall_if, a_stall_id, a_flush_id, a_flush_ex, a_rv;
  logic [31:0] a_rpc;
  logic [1:0]  a_fwd_a, a_fwd_b, a_state;
  logic [15:0] a_stall_cnt, a_flush_cnt;

  logic        b_stall_if, b_stall_id, b_flush_id, b_flush_ex, b_rv;
  logic [31:0] b_rpc;
  logic [1:0]  b_fwd_a, b_fwd_b, b_state;
  logic [3:0]  b_stall_cnt, b_flush_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_unit_v2 #(.XLEN(32), .LOAD_LAT(2), .FLUSH_DEPTH(3), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .branch(branch), .func3(func3), .alu_zero(alu_zero),
    .pc_imm(pc_imm), .alu_out(alu_out), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .stall_if(a_stall_if), .stall_id(a_stall_id), .flush_id(a_flush_id), .flush_ex(a_flush_ex),
    .redirect_valid(a_rv), .redirect_pc(a_rpc), .fwd_a(a_fwd_a), .fwd_b(a_fwd_b),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt), .dbg_state(a_state)
  );

  hazard_unit_v2 #(.XLEN(32), .LOAD_LAT(1), .FLUSH_DEPTH(1), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .branch(branch), .func3(func3), .alu_zero(alu_zero),
    .pc_imm(pc_imm), .alu_out(alu_out), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .stall_if(b_stall_if), .stall_id(b_stall_id), .flush_id(b_flush_id), .flush_ex(b_flush_ex),
    .redirect_valid(b_rv), .redirect_pc(b_rpc), .fwd_a(b_fwd_a), .fwd_b(b_fwd_b),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt), .dbg_state(b_state)
  );

  typedef struct {
    logic [1:0]  br;
    logic [2:0]  f3;
    logic        az;
    logic [31:0] pci;
    logic [31:0] alo;
    logic        mrd;
    logic [4:0]  erd, rs1, rs2;
    logic        u1, u2;
    logic [4:0]  ers1, ers2, mrdst;
    logic        mwe;
    logic [4:0]  wrdst;
    logic        wwe;
    logic        e_rv;
    logic [31:0] e_rpc;
    logic        e_stall, e_fid, e_fex;
    logic [1:0]  e_fa, e_fb;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_in();
    branch = 2'b00; func3 = 3'b000; alu_zero = 1'b0; pc_imm = '0; alu_out = '0;
    ex_mem_read = 1'b0; ex_rd = '0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0;
    id_use_rs2 = 1'b0; ex_rs1 = '0; ex_rs2 = '0; mem_rd = '0; mem_reg_write = 1'b0;
    wb_rd = '0; wb_reg_write = 1'b0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_in();
    next();
    next();
    rst = 1'b0;
  endtask

  task automatic set_hazard();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
  endtask

  initial begin
    //          br    f3     az   pc_imm     alu_out    mrd erd rs1 rs2 u1 u2 ers1 ers2 mrd mwe wrd wwe | rv rpc      st fid fex fa     fb
    vecs[0]  = '{2'b00, 3'b000, 0, 32'h0,     32'h0,     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 32'h0,   0, 0, 0, 2'b00, 2'b00};
    vecs[1]  = '{2'b01, 3'b001, 0, 32'h100,   32'h0,     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 32'h100, 0, 1, 1, 2'b00, 2'b00};
    vecs[2]  = '{2'b01, 3'b001, 1, 32'h100,   32'h0,     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 32'h0,   0, 0, 0, 2'b00, 2'b00};
    vecs[3]  = '{2'b01, 3'b000, 1, 32'h40,    32'h0,     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 32'h40,  0, 1, 1, 2'b00, 2'b00};
    vecs[4]  = '{2'b01, 3'b010, 1, 32'h40,    32'h0,     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 32'h0,   0, 0, 0, 2'b00, 2'b00};
    vecs[5]  = '{2'b01, 3'b110, 0, 32'h80,    32'h0,     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 32'h80,  0, 1, 1, 2'b00, 2'b00};
    vecs[6]  = '{2'b11, 3'b010, 0, 32'h300,   32'h0,     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 32'h300, 0, 1, 1, 2'b00, 2'b00};
    vecs[7]  = '{2'b10, 3'b000, 0, 32'h500,   32'h203,   1, 5, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0,   1, 32'h202, 0, 1, 1, 2'b00, 2'b00};
    vecs[8]  = '{2'b00, 3'b000, 0, 32'h0,     32'h0,     1, 5, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0,   0, 32'h0,   1, 0, 1, 2'b00, 2'b00};
    vecs[9]  = '{2'b00, 3'b000, 0, 32'h0,     32'h0,     1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0,   0, 32'h0,   0, 0, 0, 2'b00, 2'b00};
    vecs[10] = '{2'b00, 3'b000, 0, 32'h0,     32'h0,     1, 6, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0,   0, 32'h0,   0, 0, 0, 2'b00, 2'b00};
    vecs[11] = '{2'b00, 3'b000, 0, 32'h0,     32'h0,     1, 6, 1, 6, 1, 1, 7, 7, 7, 1, 7, 1,   0, 32'h0,   1, 0, 1, 2'b10, 2'b10};
    vecs[12] = '{2'b00, 3'b000, 0, 32'h0,     32'h0,     0, 0, 0, 0, 0, 0, 7, 2, 7, 0, 7, 1,   0, 32'h0,   0, 0, 0, 2'b01, 2'b00};
    vecs[13] = '{2'b00, 3'b000, 0, 32'h0,     32'h0,     0, 0, 0, 0, 0, 0, 0, 3, 3, 1, 0, 1,   0, 32'h0,   0, 0, 0, 2'b00, 2'b10};

    rst = 1'b1;
    clear_in();
    next();
    next();
    // Outputs under reset: flushes/stalls held low, redirect still combinational.
    set_hazard();
    branch = 2'b11; pc_imm = 32'h10;
    @(negedge clk);
    chk("rst_stall_id", {31'd0, a_stall_id}, 32'd0);
    chk("rst_flush_id", {31'd0, a_flush_id}, 32'd0);
    chk("rst_flush_ex", {31'd0, b_flush_ex}, 32'd0);
    chk("rst_redirect", {31'd0, a_rv}, 32'd1);
    next();
    chk("rst_stall_cnt", {16'd0, a_stall_cnt}, 32'd0);
    chk("rst_flush_cnt", {16'd0, a_flush_cnt}, 32'd0);
    chk("rst_state", {30'd0, a_state}, 32'd0);
    do_reset();

    for (int i = 0; i < 14; i++) begin
      branch = vecs[i].br; func3 = vecs[i].f3; alu_zero = vecs[i].az;
      pc_imm = vecs[i].pci; alu_out = vecs[i].alo; ex_mem_read = vecs[i].mrd;
      ex_rd = vecs[i].erd; id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
      id_use_rs1 = vecs[i].u1; id_use_rs2 = vecs[i].u2; ex_rs1 = vecs[i].ers1;
      ex_rs2 = vecs[i].ers2; mem_rd = vecs[i].mrdst; mem_reg_write = vecs[i].mwe;
      wb_rd = vecs[i].wrdst; wb_reg_write = vecs[i].wwe;
      @(negedge clk);
      chk($sformatf("v%0d_rv", i),       {31'd0, b_rv}, {31'd0, vecs[i].e_rv});
      chk($sformatf("v%0d_rpc", i),      b_rpc, vecs[i].e_rpc);
      chk($sformatf("v%0d_stall_id", i), {31'd0, b_stall_id}, {31'd0, vecs[i].e_stall});
      chk($sformatf("v%0d_stall_if", i), {31'd0, b_stall_if}, {31'd0, vecs[i].e_stall});
      chk($sformatf("v%0d_flush_id", i), {31'd0, b_flush_id}, {31'd0, vecs[i].e_fid});
      chk($sformatf("v%0d_flush_ex", i), {31'd0, b_flush_ex}, {31'd0, vecs[i].e_fex});
      chk($sformatf("v%0d_fwd_a", i),    {30'd0, b_fwd_a}, {30'd0, vecs[i].e_fa});
      chk($sformatf("v%0d_fwd_b", i),    {30'd0, b_fwd_b}, {30'd0, vecs[i].e_fb});
      next();
    end

    // Load-use with LOAD_LAT=2: exactly two stall cycles from a one-cycle hazard.
    do_reset();
    set_hazard();
    @(negedge clk);
    chk("ld_c0_stall_id", {31'd0, a_stall_id}, 32'd1);
    chk("ld_c0_flush_ex", {31'd0, a_flush_ex}, 32'd1);
    chk("ld_c0_flush_id", {31'd0, a_flush_id}, 32'd0);
    next();
    clear_in();
    @(negedge clk);
    chk("ld_c1_stall_id", {31'd0, a_stall_id}, 32'd1);
    chk("ld_c1_stall_if", {31'd0, a_stall_if}, 32'd1);
    chk("ld_c1_state", {30'd0, a_state}, 32'd1);
    next();
    @(negedge clk);
    chk("ld_c2_stall_id", {31'd0, a_stall_id}, 32'd0);
    chk("ld_c2_state", {30'd0, a_state}, 32'd0);
    chk("ld_stall_cnt_a", {16'd0, a_stall_cnt}, 32'd2);
    chk("ld_stall_cnt_b", {28'd0, b_stall_cnt}, 32'd1);

    // FLUSH_DEPTH=3: one redirect yields three flush_id cycles.
    do_reset();
    branch = 2'b11; pc_imm = 32'h300;
    @(negedge clk);
    chk("fl_c0_flush_id", {31'd0, a_flush_id}, 32'd1);
    chk("fl_c0_flush_ex", {31'd0, a_flush_ex}, 32'd1);
    next();
    clear_in();
    @(negedge clk);
    chk("fl_c1_flush_id", {31'd0, a_flush_id}, 32'd1);
    chk("fl_c1_flush_ex", {31'd0, a_flush_ex}, 32'd0);
    chk("fl_c1_state", {30'd0, a_state}, 32'd2);
    next();
    @(negedge clk);
    chk("fl_c2_flush_id", {31'd0, a_flush_id}, 32'd1);
    next();
    @(negedge clk);
    chk("fl_c3_flush_id", {31'd0, a_flush_id}, 32'd0);
    chk("fl_flush_cnt", {16'd0, a_flush_cnt}, 32'd1);

    // A second redirect while in FLUSH restarts the flush window.
    do_reset();
    branch = 2'b11; pc_imm = 32'h44;
    next();
    next();
    clear_in();
    @(negedge clk);
    chk("rl_c2_flush_id", {31'd0, a_flush_id}, 32'd1);
    next();
    @(negedge clk);
    chk("rl_c3_flush_id", {31'd0, a_flush_id}, 32'd1);
    next();
    @(negedge clk);
    chk("rl_c4_flush_id", {31'd0, a_flush_id}, 32'd0);
    chk("rl_flush_cnt", {16'd0, a_flush_cnt}, 32'd2);

    // Reset asserted in the second cycle of a flush window.
    do_reset();
    branch = 2'b11; pc_imm = 32'h88;
    next();
    clear_in();
    rst = 1'b1;
    @(negedge clk);
    chk("rf_rst_flush_id", {31'd0, a_flush_id}, 32'd0);
    next();
    rst = 1'b0;
    @(negedge clk);
    chk("rf_post_flush_id", {31'd0, a_flush_id}, 32'd0);
    chk("rf_post_state", {30'd0, a_state}, 32'd0);
    chk("rf_post_flush_cnt", {16'd0, a_flush_cnt}, 32'd0);

    // JALR redirect overriding an LD_WAIT stall with the hazard still present.
    do_reset();
    set_hazard();
    next();
    branch = 2'b10; alu_out = 32'h203;
    @(negedge clk);
    chk("jr_stall_id", {31'd0, a_stall_id}, 32'd0);
    chk("jr_stall_if", {31'd0, a_stall_if}, 32'd0);
    chk("jr_flush_id", {31'd0, a_flush_id}, 32'd1);
    chk("jr_flush_ex", {31'd0, a_flush_ex}, 32'd1);
    chk("jr_rpc", a_rpc, 32'h202);
    next();
    clear_in();
    @(negedge clk);
    chk("jr_state", {30'd0, a_state}, 32'd2);
    chk("jr_stall_cnt_a", {16'd0, a_stall_cnt}, 32'd1);
    chk("jr_stall_cnt_b", {28'd0, b_stall_cnt}, 32'd1);
    chk("jr_flush_cnt_b", {28'd0, b_flush_cnt}, 32'd1);

    // Counter saturation: 20 stall cycles, then 20 redirect cycles.
    do_reset();
    set_hazard();
    repeat (20) next();
    clear_in();
    @(negedge clk);
    chk("sat_stall_cnt_b", {28'd0, b_stall_cnt}, 32'd15);
    chk("sat_stall_cnt_a", {16'd0, a_stall_cnt}, 32'd20);
    do_reset();
    branch = 2'b11; pc_imm = 32'h1000;
    repeat (20) next();
    clear_in();
    @(negedge clk);
    chk("sat_flush_cnt_b", {28'd0, b_flush_cnt}, 32'd15);
    chk("sat_flush_cnt_a", {16'd0, a_flush_cnt}, 32'd20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
